// File: rtl/present_pkg.sv
// Shared types, constants and index maps for the generalised PRESENT bit-permutation layer.
package present_pkg;

    localparam int unsigned PRESENT_BW = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } pbox_state_t;

    // Forward map: bit i lands at i*bw/4 mod (bw-1); the top bit is a fixed point.
    function automatic int unsigned pbox_fwd_idx(input int unsigned i, input int unsigned bw);
        if (i == bw - 1) return bw - 1;
        return (i * (bw / 4)) % (bw - 1);
    endfunction

    // Inverse map: bit j lands at j*4 mod (bw-1); 4 is the modular inverse of bw/4.
    function automatic int unsigned pbox_inv_idx(input int unsigned j, input int unsigned bw);
        if (j == bw - 1) return bw - 1;
        return (j * 4) % (bw - 1);
    endfunction

endpackage

// File: rtl/present_pbox_perm.sv
// One combinational application of the PRESENT bit permutation, forward or inverse.
module present_pbox_perm
    import present_pkg::*;
#(
    parameter int unsigned BW = PRESENT_BW
) (
    input  logic [BW-1:0] dat,
    input  logic          inv,
    output logic [BW-1:0] res
);

    logic [BW-1:0] fwd_map;
    logic [BW-1:0] inv_map;

    // Pure wiring: both maps are bijections, so every destination bit has one driver.
    for (genvar i = 0; i < BW; i++) begin : g_map
        localparam int unsigned FI = pbox_fwd_idx(i, BW);
        localparam int unsigned II = pbox_inv_idx(i, BW);
        assign fwd_map[FI] = dat[i];
        assign inv_map[II] = dat[i];
    end

    assign res = inv ? inv_map : fwd_map;

endmodule

// File: rtl/present_pbox_iter.sv
// Iterative PRESENT permutation: applies the map in_cnt times, one step per clock, with
// valid/ready handshakes. Define PRESENT_PBOX_PERF_EN to add a saturating busy-cycle counter.
module present_pbox_iter
    import present_pkg::*;
#(
    parameter int unsigned BW = PRESENT_BW,
    parameter int unsigned CW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [BW-1:0] in_dat,
    input  logic          in_inv,
    input  logic [CW-1:0] in_cnt,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [BW-1:0] out_dat,
    output logic          busy
`ifdef PRESENT_PBOX_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    pbox_state_t   state;
    logic [BW-1:0] data;
    logic          inv;
    logic [CW-1:0] remaining;
    logic [BW-1:0] perm_dat;
    logic          accept;

    present_pbox_perm #(.BW(BW)) u_perm (
        .dat (data),
        .inv (inv),
        .res (perm_dat)
    );

    // A DONE handoff and a new accept may share a cycle, so in_ready looks at out_ready.
    assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign out_dat  = data;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            data      <= '0;
            inv       <= 1'b0;
            remaining <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (accept) begin
            data      <= in_dat;
            inv       <= in_inv;
            remaining <= in_cnt;
            busy      <= 1'b1;
            if (in_cnt == '0) begin
                state     <= DONE;
                out_valid <= 1'b1;
            end else begin
                state     <= RUN;
                out_valid <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    data      <= perm_dat;
                    remaining <= remaining - CW'(1);
                    if (remaining == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef PRESENT_PBOX_PERF_EN
    // Busy-cycle counter, sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles <= '0;
        end else if (busy && (perf_cycles != '1)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule
